fft_twiddle_gen: RTL

Parametrised, stage-sequenced twiddle-factor generator for the radix-2 FFT datapath. It replaces the per-stage hand-filled twiddle tables with one block that serves any stage of an N-point FFT. Only a quarter-wave cosine table is stored, and full-circle cos/sin values are derived by quadrant symmetry. After a `start`, the block streams the butterfly-ordered twiddles for the requested stage to the butterfly unit over a valid/ready handshake.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/twiddle_qrom.sv | 47 ++++
 rtl/fft_twiddle_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT twiddle generator: Q-format helpers, quadrant
// codes, sequencer states and the bit-reverse helper.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tw_state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam int DATA_W_DEF = 14;
  localparam int ONE        = 1 << (DATA_W_DEF - 2);

  // +1.0 in signed Q2.(data_w-2)
  function automatic int q_one(input int data_w);
    return 1 << (data_w - 2);
  endfunction

  // Reverse the low nbits of v; bits at and above nbits come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int nbits);
    logic [15:0] r;
    int          idx;
    r = 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (i < nbits) begin
        idx  = nbits - 1 - i;
        r[i] = v[idx[3:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM (N/4+1 entries) with two registered read ports,
// T[r] and T[N/4-r]. Contents are computed at elaboration.
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int LOG2_N = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LOG2_N-3:0]        addr,
  output logic signed [DATA_W-1:0] t_r,
  output logic signed [DATA_W-1:0] t_nr
);

  localparam int  QN = 1 << (LOG2_N - 2);
  localparam real PI = 3.14159265358979323846;

  logic signed [DATA_W-1:0] rom_s [0:QN];
  logic        [LOG2_N-2:0] addr_nr_s;
  logic signed [DATA_W-1:0] t_r_r;
  logic signed [DATA_W-1:0] t_nr_r;

  // Table values are non-negative, so adding 0.5 before truncation rounds half away from zero.
  for (genvar i = 0; i <= QN; i++) begin : g_rom
    localparam int V = $rtoi($cos(2.0 * PI * real'(i) / real'(4 * QN)) * real'(q_one(DATA_W)) + 0.5);
    assign rom_s[i] = V[DATA_W-1:0];
  end

  assign addr_nr_s = (LOG2_N - 1)'(QN) - {1'b0, addr};

  // Registered dual read, held while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_r_r  <= {DATA_W{1'b0}};
      t_nr_r <= {DATA_W{1'b0}};
    end else if (en) begin
      t_r_r  <= rom_s[addr];
      t_nr_r <= rom_s[addr_nr_s];
    end
  end

  assign t_r  = t_r_r;
  assign t_nr = t_nr_r;

endmodule

// File: rtl/fft_twiddle_gen.sv
// Stage-sequenced radix-2 twiddle generator: counter/FSM, quarter-wave ROM read,
// quadrant symmetry stage. Define TWIDLE_BITREV_EN for bit-reversed twiddle order.
module fft_twiddle_gen
  import fft_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int LOG2_N = 10,
  parameter int STG_W  = $clog2(LOG2_N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [STG_W-1:0]         stage,
  output logic                     busy,
  output logic                     tw_valid,
  input  logic                     tw_ready,
  output logic                     tw_last,
  output logic [LOG2_N-1:0]        tw_index,
  output logic signed [DATA_W-1:0] cos_data,
  output logic signed [DATA_W-1:0] sin_data
);

  localparam int               BW     = LOG2_N - 1;
  localparam logic [BW-1:0]    LAST_B = {BW{1'b1}};
  localparam logic [STG_W-1:0] SH_MAX = STG_W'(LOG2_N - 1);
  localparam logic [STG_W:0]   N_STG  = (STG_W + 1)'(LOG2_N);

  tw_state_e                state_r, state_s;
  logic [BW-1:0]            b_r;
  logic [STG_W-1:0]         stg_r;
  logic                     issue_s;
  logic                     adv_s;
  logic [BW-1:0]            mask_s;
  logic [BW-1:0]            j_s;
  logic [BW-1:0]            j_sel_s;
  logic [STG_W-1:0]         shamt_s;
  logic [LOG2_N-1:0]        k_s;

  logic                     v1_r;
  logic                     last1_r;
  logic [LOG2_N-1:0]        k1_r;
  logic [1:0]               q_s;
  logic signed [DATA_W-1:0] t_r_s;
  logic signed [DATA_W-1:0] t_nr_s;
  logic signed [DATA_W-1:0] cos_s;
  logic signed [DATA_W-1:0] sin_s;

  logic                     busy_r;
  logic                     valid_r;
  logic                     last_r;
  logic [LOG2_N-1:0]        index_r;
  logic signed [DATA_W-1:0] cos_r;
  logic signed [DATA_W-1:0] sin_r;

  // Only a presented-but-unaccepted twiddle stalls; valid never looks at ready.
  assign adv_s   = ~valid_r | tw_ready;
  assign mask_s  = ~(LAST_B << stg_r);
  assign j_s     = b_r & mask_s;
`ifdef TWIDLE_BITREV_EN
  assign j_sel_s = BW'(bitrev(16'(j_s), int'(stg_r)));
`else
  assign j_sel_s = j_s;
`endif
  assign shamt_s = SH_MAX - stg_r;
  assign k_s     = {1'b0, j_sel_s} << shamt_s;

  twiddle_qrom #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_qrom (
    .clk  (clk),
    .rst  (rst),
    .en   (adv_s),
    .addr (k_s[LOG2_N-3:0]),
    .t_r  (t_r_s),
    .t_nr (t_nr_s)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and address-issue decode.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && ({1'b0, stage} < N_STG)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (adv_s) begin
          issue_s = 1'b1;
          if (b_r == LAST_B) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (valid_r && tw_ready && last_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Quadrant symmetry on the ROM read register.
  always_comb begin
    q_s   = k1_r[LOG2_N-1 -: 2];
    cos_s = t_r_s;
    sin_s = t_nr_s;
    case (q_s)
      QUAD_0: begin
        cos_s = t_r_s;
        sin_s = t_nr_s;
      end
      QUAD_1: begin
        cos_s = -t_nr_s;
        sin_s = t_r_s;
      end
      QUAD_2: begin
        cos_s = -t_r_s;
        sin_s = -t_nr_s;
      end
      QUAD_3: begin
        cos_s = t_nr_s;
        sin_s = -t_r_s;
      end
      default: begin
        cos_s = t_r_s;
        sin_s = t_nr_s;
      end
    endcase
  end

  // Butterfly counter, stage capture and both pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r     <= {BW{1'b0}};
      stg_r   <= {STG_W{1'b0}};
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      k1_r    <= {LOG2_N{1'b0}};
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      index_r <= {LOG2_N{1'b0}};
      cos_r   <= {DATA_W{1'b0}};
      sin_r   <= {DATA_W{1'b0}};
    end else begin
      busy_r <= (state_s != ST_IDLE);
      if ((state_r == ST_IDLE) && (state_s == ST_RUN)) begin
        stg_r <= stage;
        b_r   <= {BW{1'b0}};
      end else if (issue_s) begin
        b_r <= b_r + 1'b1;
      end
      if (adv_s) begin
        v1_r    <= issue_s;
        last1_r <= issue_s && (b_r == LAST_B);
        k1_r    <= k_s;
        valid_r <= v1_r;
        last_r  <= last1_r;
        if (v1_r) begin
          index_r <= k1_r;
          cos_r   <= cos_s;
          sin_r   <= sin_s;
        end
      end
    end
  end

  assign busy     = busy_r;
  assign tw_valid = valid_r;
  assign tw_last  = last_r;
  assign tw_index = index_r;
  assign cos_data = cos_r;
  assign sin_data = sin_r;

endmodule
